// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and requester indices for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - per-transaction cycle counter raising terminal at TIMEOUT-1
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clear, enable};
      assign terminal = 1'b0;
    end else begin : g_on
      logic [CW-1:0] count;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= count + 1'b1;
        end
      end

      // The arbiter leaves BUSY on terminal, so the count never wraps.
      assign terminal = (count == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter for a single-port memory with timeout
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sel_o,
  output logic              busy_o
);

  arb_state_t state, next_state;
  logic       last;
  logic       terminal;
  logic       grant_sel;

  logic              last_n, sel_n, we_n, err_n;
  logic              mem_req_n, busy_n, f_ack_n, d_ack_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == IDLE),
    .enable   ((state == BUSY) && !mem_ack),
    .terminal (terminal)
  );

  // On a tie the requester that was not served last wins; otherwise the sole requester.
  assign grant_sel = (f_req && d_req) ? ~last : d_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (f_req || d_req) next_state = BUSY;
      BUSY: if (mem_ack || terminal) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    last_n  = last;
    sel_n   = sel_o;
    addr_n  = mem_addr;
    we_n    = mem_we;
    wdata_n = mem_wdata;
    rdata_n = rdata_o;
    err_n   = err_o;
    case (state)
      IDLE: begin
        if (f_req || d_req) begin
          sel_n   = grant_sel;
          addr_n  = (grant_sel == REQ_D) ? d_addr : f_addr;
          we_n    = (grant_sel == REQ_D) ? d_we : 1'b0;
          wdata_n = (grant_sel == REQ_D) ? d_wdata : '0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          rdata_n = mem_rdata;
          err_n   = 1'b0;
        end else if (terminal) begin
          rdata_n = '0;
          err_n   = 1'b1;
        end
      end
      DONE: last_n = sel_o;
      default: ;
    endcase
    mem_req_n = (next_state == BUSY);
    busy_n    = (next_state != IDLE);
    f_ack_n   = (next_state == DONE) && (sel_o == REQ_F);
    d_ack_n   = (next_state == DONE) && (sel_o == REQ_D);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last      <= 1'b1;
      sel_o     <= REQ_F;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      mem_req   <= 1'b0;
      busy_o    <= 1'b0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      last      <= last_n;
      sel_o     <= sel_n;
      mem_addr  <= addr_n;
      mem_we    <= we_n;
      mem_wdata <= wdata_n;
      rdata_o   <= rdata_n;
      err_o     <= err_n;
      mem_req   <= mem_req_n;
      busy_o    <= busy_n;
      f_ack     <= f_ack_n;
      d_ack     <= d_ack_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req, d_we, mem_ack;
  logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic        f_ack, d_ack, err_o, mem_req, mem_we, sel_o, busy_o;
  logic [31:0] rdata_o, mem_addr, mem_wdata;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_we      (d_we),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .err_o     (err_o),
    .rdata_o   (rdata_o),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .sel_o     (sel_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_sel", 32'(sel_o), 32'd0);
    chk("rst_acks", 32'({f_ack, d_ack, err_o}), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    rst_n = 1'b1;

    // Fetch only: two-cycle request to ack
    f_req = 1'b1; f_addr = 32'h100;
    tick();
    chk("f_mem_req", 32'(mem_req), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", 32'(mem_we), 32'd0);
    chk("f_sel", 32'(sel_o), 32'd0);
    chk("f_ack_early", 32'(f_ack), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h00500093;
    tick();
    chk("f_ack", 32'(f_ack), 32'd1);
    chk("f_d_ack", 32'(d_ack), 32'd0);
    chk("f_rdata", rdata_o, 32'h00500093);
    chk("f_err", 32'(err_o), 32'd0);
    chk("f_done_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0; f_req = 1'b0;
    tick();
    chk("f_idle_busy", 32'(busy_o), 32'd0);
    chk("f_ack_pulse", 32'(f_ack), 32'd0);

    // Simultaneous after reset: F first, then strict alternation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    f_req = 1'b1; f_addr = 32'h104;
    d_req = 1'b1; d_addr = 32'h2000; d_we = 1'b1; d_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr%0d_sel", i), 32'(sel_o), 32'(i % 2));
      chk($sformatf("rr%0d_addr", i), mem_addr, (i % 2) ? 32'h2000 : 32'h104);
      chk($sformatf("rr%0d_we", i), 32'(mem_we), 32'(i % 2));
      chk($sformatf("rr%0d_wdata", i), mem_wdata, (i % 2) ? 32'hDEADBEEF : 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(i);
      tick();
      chk($sformatf("rr%0d_acks", i), 32'({f_ack, d_ack}), (i % 2) ? 32'b01 : 32'b10);
      chk($sformatf("rr%0d_rdata", i), rdata_o, 32'h1000 + 32'(i));
      mem_ack = 1'b0;
      tick();
    end
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("rr_idle", 32'(busy_o), 32'd0);

    // Timeout with payload change during BUSY
    d_req = 1'b1; d_addr = 32'h2000;
    tick();
    chk("to_grant_sel", 32'(sel_o), 32'd1);
    d_addr = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("to_req%0d", i), 32'(mem_req), 32'd1);
      tick();
      chk($sformatf("to_addr%0d", i), mem_addr, 32'h2000);
    end
    chk("to_req3", 32'(mem_req), 32'd1);
    tick();
    chk("to_d_ack", 32'(d_ack), 32'd1);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_rdata", rdata_o, 32'd0);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    d_req = 1'b0;
    tick();

    // Ack in the last BUSY cycle beats the timeout
    f_req = 1'b1; f_addr = 32'h200;
    tick(); tick(); tick(); tick();
    chk("bd_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    chk("bd_f_ack", 32'(f_ack), 32'd1);
    chk("bd_err", 32'(err_o), 32'd0);
    chk("bd_rdata", rdata_o, 32'hCAFEF00D);
    mem_ack = 1'b0; f_req = 1'b0;
    tick();

    // Reset mid-BUSY discards the transaction
    d_req = 1'b1; d_addr = 32'h40;
    tick();
    chk("rm_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0; d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rm_mem_req", 32'(mem_req), 32'd0);
    chk("rm_busy", 32'(busy_o), 32'd0);
    chk("rm_acks", 32'({f_ack, d_ack}), 32'd0);

    // Stray mem_ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ig_busy", 32'(busy_o), 32'd0);
    chk("ig_acks", 32'({f_ack, d_ack}), 32'd0);
    tick();
    chk("ig_acks2", 32'({f_ack, d_ack}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
